uart_rx_logic: RTL and testbench
================================

# uart_rx_logic

- Receive half of the UART block: deserialises the asynchronous `rx_i` line into parallel data words.
- Runtime format configuration uses the same encoding as the transmit side: data bits, parity, stop bits and baud divisor.
- Sits between the pin and the user/register logic.
- Delivers each word with a one-cycle valid pulse and per-frame parity/framing error flags.

## Interface

Parameters: none (all format settings are runtime ports).

Ports (clock and reset first):
- `sys_clk_i`  in  1  system clock (50 MHz nominal).
- `rst_i`  in  1  asynchronous, active-high reset.
- `uart_data_bit`  in  4  data bits per frame, 5–8; values <5 treated as 5, >8 treated as 8.
- `baud_cnt_max`  in  16  bit period minus one, in `sys_clk_i` cycles (f_clk/baud − 1); minimum 4.
- `uart_parity_bit`  in  2  0 none, 1 odd, 2 even, 3 none.
- `uart_stop_bit`  in  2  0/3 one stop bit, 1 = 1.5, 2 = 2.
- `rx_i`  in  1  serial input, idle high; asynchronous to `sys_clk_i`.
- `rx_data_o`  out  8  received word, LSB = first data bit; bits at and above `uart_data_bit` are 0.
- `rx_data_valid_o`  out  1  one-cycle pulse: `rx_data_o` and error flags are valid.
- `rx_parity_err_o`  out  1  parity mismatch; meaningful only with `rx_data_valid_o`.
- `rx_frame_err_o`  out  1  a checked stop bit was sampled low; meaningful only with `rx_data_valid_o`.
- `rx_busy_o`  out  1  high whenever the state is not IDLE.

## Operation

**Input conditioning**
- `rx_i` passes through a 2-FF synchroniser; both flops reset to 1.
- A third flop holds the previous synchronised value for falling-edge detection.

**Baud counter**
- `baud_cnt` counts 0..`baud_cnt_max` while not in IDLE, wraps to 0, and is held at 0 in IDLE.
- Sample point (`mid`) is `baud_cnt == baud_cnt_max >> 1`.

**States:** IDLE, START, DATA, PARITY, STOP.
- IDLE → START on a synchronised 1→0 edge. A line held low never triggers, including after a break or framing error; a high level must be seen first.
- START: sample at `mid`.
  - Sample 0: go to DATA, bit counter = 0.
  - Sample 1: glitch; return to IDLE with no output.
- DATA: at each `mid`, sample into a shift register at position `bit_cnt`.
  - After bit `uart_data_bit`−1, go to PARITY if parity is 1 or 2, otherwise to STOP.
- PARITY: at `mid`, compare the sample with the expected parity over the received data bits only.
  - Odd: XNOR-reduce. Even: XOR-reduce.
  - Go to STOP.
- STOP: check the first stop bit at `mid`.
  - For `uart_stop_bit`==2, also check the second stop bit at the next `mid`.
  - For 1.5 stop bits, only the first is checked; the trailing half bit is absorbed by IDLE edge detection.
  - After the last checked sample, return to IDLE.
  - Early return to IDLE tolerates ±half-bit drift on back-to-back frames.

**Output on return from STOP**
- `rx_data_o` is loaded and held until the next valid word.
- `rx_data_valid_o` pulses for one cycle with `rx_parity_err_o` and `rx_frame_err_o` (0 when no parity is selected).
- Data is delivered even when errors are flagged.

**Stability:** format ports must be stable while `rx_busy_o` is high. A mid-frame change gives undefined data but the FSM must still reach IDLE.

## Timing

- Reset values: `rx_data_o`=0, `rx_data_valid_o`=0, `rx_parity_err_o`=0, `rx_frame_err_o`=0, `rx_busy_o`=0; state IDLE, counters 0.
- Reset mid-frame aborts immediately with no valid pulse; reception restarts on the next edge after reset is released.
- Edge latency: a fall on `rx_i` at cycle 0 is detected at cycle 3 (2 synchroniser + 1 edge flop). START is entered and `baud_cnt`=0 at cycle 4.
- Sample k (start = 0) occurs at cycle 4 + k·(`baud_cnt_max`+1) + (`baud_cnt_max`>>1).
- `rx_data_valid_o` is asserted in the cycle after the final stop-bit sample (plus 1 with the majority option).
- `rx_busy_o` deasserts in the same cycle that `rx_data_valid_o` asserts.
- A new start edge is accepted from the cycle after the return to IDLE.

## Configuration

- Macro: `UART_RX_MAJORITY_EN`.
- Defined: each bit is sampled at `mid`−1, `mid` and `mid`+1 and resolved by 2-of-3 majority at `mid`+1. This applies to the START glitch check as well. All bit decisions and the valid pulse move one cycle later.
- Undefined: single sample at `mid`.

## Test plan

1. `baud_cnt_max`=433, 8N1, byte 0xA5 → one `rx_data_valid_o` pulse, `rx_data_o`=0xA5, both error flags 0.
2. 7 data bits, even parity, 2 stop, value 0x35 with correct parity, then the same frame with the parity bit inverted → `rx_data_o`=0x35 both times; `rx_parity_err_o` 0 then 1.
3. 8N1 0x3C with the stop bit driven low, line held low 3 bit times, then 0x81 → first word 0x3C with `rx_frame_err_o`=1, no spurious frame during the low period, then 0x81 clean.
4. 200-cycle low pulse on idle `rx_i` (below half bit) → no valid pulse; `rx_busy_o` high for ~220 cycles then 0.
5. Back-to-back 5O1.5 frames 0x1F, 0x00 with the baud 2% fast relative to `baud_cnt_max` → both words correct, parity errors 0.
6. Assert `rst_i` during DATA bit 3 of 0xFF → all outputs 0 immediately, no valid pulse; the next full frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_rx_logic.sv
// UART receiver: synchronised rx line, runtime frame format, one-cycle valid pulse with error flags.
// Optional define UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx_logic (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic [3:0]  uart_data_bit,
  input  logic [15:0] baud_cnt_max,
  input  logic [1:0]  uart_parity_bit,
  input  logic [1:0]  uart_stop_bit,
  input  logic        rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_data_valid_o,
  output logic        rx_parity_err_o,
  output logic        rx_frame_err_o,
  output logic        rx_busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1, r_sync2, r_prev;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic        r_stop_cnt;
  logic [7:0]  r_shift;
  logic        r_par_err, r_frm_err;
  logic [7:0]  r_data;
  logic        r_valid, r_perr, r_ferr;

  logic        w_fall, w_tick, w_bit;
  logic [15:0] w_half;
  logic [3:0]  w_nbits, w_last_idx;
  logic        w_last_bit, w_par_en, w_two_stop, w_par_exp, w_frame_done;

  assign w_fall     = r_prev & ~r_sync2;
  assign w_half     = baud_cnt_max >> 1;
  assign w_nbits    = (uart_data_bit < 4'd5) ? 4'd5 : ((uart_data_bit > 4'd8) ? 4'd8 : uart_data_bit);
  assign w_last_idx = w_nbits - 4'd1;
  assign w_last_bit = (r_bit_cnt == w_last_idx[2:0]);
  assign w_par_en   = (uart_parity_bit == 2'd1) || (uart_parity_bit == 2'd2);
  assign w_two_stop = (uart_stop_bit == 2'd2);
  assign w_par_exp  = (uart_parity_bit == 2'd1) ? ~^r_shift : ^r_shift;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_h0, r_h1;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h0 <= 1'b1;
      r_h1 <= 1'b1;
    end else begin
      r_h0 <= r_sync2;
      r_h1 <= r_h0;
    end
  end

  // Vote resolves at mid+1 using the samples from mid-1, mid and mid+1
  assign w_tick = (r_baud_cnt == w_half + 16'd1);
  assign w_bit  = (r_h1 & r_h0) | (r_h1 & r_sync2) | (r_h0 & r_sync2);
`else
  assign w_tick = (r_baud_cnt == w_half);
  assign w_bit  = r_sync2;
`endif

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START:  if (w_tick) w_next = w_bit ? S_IDLE : S_DATA;
      S_DATA:   if (w_tick && w_last_bit) w_next = w_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_next = S_STOP;
      S_STOP:   if (w_tick && !(w_two_stop && !r_stop_cnt)) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_frame_done = (r_state == S_STOP) && (w_next == S_IDLE);

  // >= rather than == so a mid-frame shrink of baud_cnt_max still wraps
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i)                                        r_baud_cnt <= '0;
    else if (r_state == S_IDLE || w_next == S_IDLE)   r_baud_cnt <= '0;
    else if (r_baud_cnt >= baud_cnt_max)              r_baud_cnt <= '0;
    else                                              r_baud_cnt <= r_baud_cnt + 16'd1;
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt  <= '0;
          r_stop_cnt <= 1'b0;
          r_shift    <= '0;
          r_par_err  <= 1'b0;
          r_frm_err  <= 1'b0;
        end
        S_DATA: if (w_tick) begin
          r_shift[r_bit_cnt] <= w_bit;
          r_bit_cnt          <= r_bit_cnt + 3'd1;
        end
        S_PARITY: if (w_tick) r_par_err <= w_bit ^ w_par_exp;
        S_STOP: if (w_tick) begin
          r_stop_cnt <= 1'b1;
          if (!w_bit) r_frm_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_frame_done;
      if (w_frame_done) begin
        r_data <= r_shift;
        r_perr <= w_par_en & r_par_err;
        r_ferr <= r_frm_err | ~w_bit;
      end
    end
  end

  always_comb begin
    rx_busy_o       = (r_state != S_IDLE);
    rx_data_o       = r_data;
    rx_data_valid_o = r_valid;
    rx_parity_err_o = r_perr;
    rx_frame_err_o  = r_ferr;
  end

endmodule

// File: tb/tb_uart_rx_logic.sv
// Self-checking bench for uart_rx_logic: directed plan items plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_logic;

  logic        sys_clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  uart_data_bit;
  logic [15:0] baud_cnt_max;
  logic [1:0]  uart_parity_bit;
  logic [1:0]  uart_stop_bit;
  logic        rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_data_valid_o, rx_parity_err_o, rx_frame_err_o, rx_busy_o;

  uart_rx_logic dut (
    .sys_clk_i(sys_clk_i), .rst_i(rst_i), .uart_data_bit(uart_data_bit),
    .baud_cnt_max(baud_cnt_max), .uart_parity_bit(uart_parity_bit),
    .uart_stop_bit(uart_stop_bit), .rx_i(rx_i), .rx_data_o(rx_data_o),
    .rx_data_valid_o(rx_data_valid_o), .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o(rx_frame_err_o), .rx_busy_o(rx_busy_o)
  );

  always #10 sys_clk_i = ~sys_clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_fall;
  int g_lat;
  bit g_busy;
  bit g_pbit;

  logic [7:0] q_data[$];
  bit         q_perr[$], q_ferr[$], q_busy[$];
  int         q_cyc[$];

  always @(posedge sys_clk_i) cyc <= cyc + 1;

  always @(negedge sys_clk_i) begin
    if (!rst_i && rx_data_valid_o) begin
      q_data.push_back(rx_data_o);
      q_perr.push_back(rx_parity_err_o);
      q_ferr.push_back(rx_frame_err_o);
      q_busy.push_back(rx_busy_o);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_bits(input int v);
    return (v < 5) ? 5 : ((v > 8) ? 8 : v);
  endfunction

  // Frame-level parity rule: odd = total ones (data + parity bit) odd, even = total even
  function automatic bit model_perr(input logic [7:0] d, input bit pbit, input int par);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (par == 1) return (ones % 2) == 0;
    if (par == 2) return (ones % 2) == 1;
    return 1'b0;
  endfunction

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge sys_clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input int par, input int stp,
                            input int per, input bit flip, input bit stop_low);
    int ones;
    t_fall = cyc;
    hold(1'b0, per);
    for (int i = 0; i < nb; i++) hold(d[i], per);
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    g_pbit = 1'b0;
    if (par == 1 || par == 2) begin
      g_pbit = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      g_pbit = g_pbit ^ flip;
      hold(g_pbit, per);
    end
    hold(!stop_low, per);
    if (stp == 1) hold(1'b1, per / 2);
    if (stp == 2) hold(1'b1, per);
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input bit p, input bit f);
    logic [7:0] od;
    logic op, of;
    if (q_data.size() > 0) begin
      od = q_data.pop_front();
      op = q_perr.pop_front();
      of = q_ferr.pop_front();
      g_busy = q_busy.pop_front();
      g_lat = q_cyc.pop_front() - t_fall;
    end else begin
      od = 'x; op = 'x; of = 'x; g_busy = 1'b1; g_lat = -1;
    end
    chk({tag, "_data"}, 32'(od), 32'(d));
    chk({tag, "_perr"}, 32'(op), 32'(p));
    chk({tag, "_ferr"}, 32'(of), 32'(f));
  endtask

  task automatic set_fmt(input int nb, input int par, input int stp, input int bmax);
    uart_data_bit   = 4'(nb);
    uart_parity_bit = 2'(par);
    uart_stop_bit   = 2'(stp);
    baud_cnt_max    = 16'(bmax);
  endtask

  initial begin
    int lat_exp, busy_cnt, nb, par, stp, bmax, per;
    logic [7:0] d, mask;
    bit flip, slow;

    rst_i = 1'b1;
    rx_i  = 1'b1;
    set_fmt(8, 0, 0, 433);
    repeat (3) @(negedge sys_clk_i);
    chk("rst_data", 32'(rx_data_o), 0);
    chk("rst_valid", 32'(rx_data_valid_o), 0);
    chk("rst_perr", 32'(rx_parity_err_o), 0);
    chk("rst_ferr", 32'(rx_frame_err_o), 0);
    chk("rst_busy", 32'(rx_busy_o), 0);
    rst_i = 1'b0;
    hold(1'b1, 10);

    // 8N1 0xA5 plus latency to valid (stop = sample 9)
    send_frame(8'hA5, 8, 0, 0, 434, 0, 0);
    hold(1'b1, 4);
    chk("t1_count", q_data.size(), 1);
    check_word("t1", 8'hA5, 0, 0);
    lat_exp = 4 + 9 * 434 + 216 + 1;
`ifdef UART_RX_MAJORITY_EN
    lat_exp += 1;
`endif
    chk("t1_latency", 32'((g_lat >= lat_exp - 2) && (g_lat <= lat_exp + 2)), 1);
    chk("t1_busy_at_valid", 32'(g_busy), 0);

    // 7E2, correct then inverted parity
    set_fmt(7, 2, 2, 433);
    send_frame(8'h35, 7, 2, 2, 434, 0, 0);
    hold(1'b1, 4);
    check_word("t2a", 8'h35, model_perr(8'h35, g_pbit, 2), 0);
    send_frame(8'h35, 7, 2, 2, 434, 1, 0);
    hold(1'b1, 4);
    check_word("t2b", 8'h35, 1, 0);
    chk("t2_count", q_data.size(), 0);

    // framing error followed by break-like low line
    set_fmt(8, 0, 0, 433);
    send_frame(8'h3C, 8, 0, 0, 434, 0, 1);
    hold(1'b0, 3 * 434);
    chk("t3_count_low", q_data.size(), 1);
    check_word("t3a", 8'h3C, 0, 1);
    hold(1'b1, 2 * 434);
    send_frame(8'h81, 8, 0, 0, 434, 0, 0);
    hold(1'b1, 4);
    chk("t3_count", q_data.size(), 1);
    check_word("t3b", 8'h81, 0, 0);

    // short glitch rejected at the start-bit check
    busy_cnt = 0;
    rx_i = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (i == 200) rx_i = 1'b1;
      @(negedge sys_clk_i);
      if (rx_busy_o) busy_cnt++;
    end
    chk("t4_busy_len", 32'((busy_cnt >= 214) && (busy_cnt <= 222)), 1);
    chk("t4_count", q_data.size(), 0);

    // back-to-back 5O1.5 with the line 2% fast
    set_fmt(5, 1, 1, 433);
    send_frame(8'h1F, 5, 1, 1, 425, 0, 0);
    send_frame(8'h00, 5, 1, 1, 425, 0, 0);
    hold(1'b1, 4);
    chk("t5_count", q_data.size(), 2);
    check_word("t5a", 8'h1F, 0, 0);
    check_word("t5b", 8'h00, 0, 0);

    // reset during data bit 3 of 0xFF
    set_fmt(8, 0, 0, 433);
    hold(1'b0, 434);
    hold(1'b1, 3 * 434 + 200);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_data", 32'(rx_data_o), 0);
    chk("t6_rst_busy", 32'(rx_busy_o), 0);
    chk("t6_rst_valid", 32'(rx_data_valid_o), 0);
    hold(1'b1, 5);
    rst_i = 1'b0;
    hold(1'b1, 20);
    chk("t6_no_word", q_data.size(), 0);
    send_frame(8'h42, 8, 0, 0, 434, 0, 0);
    hold(1'b1, 4);
    chk("t6_count", q_data.size(), 1);
    check_word("t6", 8'h42, 0, 0);

    // randomized formats, including out-of-range data widths
    for (int k = 0; k < 12; k++) begin
      nb   = int'($urandom_range(0, 15));
      par  = int'($urandom_range(0, 3));
      stp  = int'($urandom_range(0, 3));
      bmax = int'($urandom_range(15, 60));
      d    = 8'($urandom);
      flip = ($urandom_range(0, 1) == 1);
      slow = ($urandom_range(0, 3) == 0);
      per  = bmax + 1;
      set_fmt(nb, par, stp, bmax);
      hold(1'b1, 3);
      mask = 8'((1 << clamp_bits(nb)) - 1);
      send_frame(d, clamp_bits(nb), par, stp, per, flip, slow);
      hold(1'b1, 3 * per);
      chk($sformatf("rnd%0d_count", k), q_data.size(), 1);
      check_word($sformatf("rnd%0d", k), d & mask, model_perr(d & mask, g_pbit, par), slow);
      q_data.delete(); q_perr.delete(); q_ferr.delete(); q_busy.delete(); q_cyc.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
